ysyx_22050019_mem_rr_sched: RTL and testbench

- Serialising scheduler between the two memory requesters in the core: the icache miss port (S0, read only) and the LSU (S1, read and write).
- Drives the single AXI-lite master port to the SRAM.
- Allows one transaction in flight at a time, with LSU priority and bounded icache starvation.
- Replaces the combinational stall hack that sits between the IFU and the bus.

---
 rtl/ysyx_22050019_mem_rr_sched.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_22050019_mem_rr_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_mem_rr_sched.sv
// Single-outstanding AXI-lite scheduler between the icache miss port (S0, read-only)
// and the LSU (S1), with LSU priority and a bounded icache starvation window.
module ysyx_22050019_mem_rr_sched #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s0_ar_valid,
    output logic                s0_ar_ready,
    input  logic [ADDR_W-1:0]   s0_ar_addr,
    output logic                s0_r_valid,
    input  logic                s0_r_ready,
    output logic [1:0]          s0_r_resp,
    output logic [DATA_W-1:0]   s0_r_data,
    input  logic                s1_aw_valid,
    output logic                s1_aw_ready,
    input  logic [ADDR_W-1:0]   s1_aw_addr,
    input  logic                s1_w_valid,
    output logic                s1_w_ready,
    input  logic [DATA_W-1:0]   s1_w_data,
    input  logic [DATA_W/8-1:0] s1_w_strb,
    output logic                s1_b_valid,
    input  logic                s1_b_ready,
    output logic [1:0]          s1_b_resp,
    input  logic                s1_ar_valid,
    output logic                s1_ar_ready,
    input  logic [ADDR_W-1:0]   s1_ar_addr,
    output logic                s1_r_valid,
    input  logic                s1_r_ready,
    output logic [1:0]          s1_r_resp,
    output logic [DATA_W-1:0]   s1_r_data,
    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [ADDR_W-1:0]   m_aw_addr,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_strb,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [1:0]          m_b_resp,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [ADDR_W-1:0]   m_ar_addr,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [1:0]          m_r_resp,
    input  logic [DATA_W-1:0]   m_r_data,
    output logic [1:0]          grant_o
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_S0RD = 2'b01,
        OWN_S1RD = 2'b10,
        OWN_S1WR = 2'b11
    } owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               own_s0;
    logic               own_ar_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            starve_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign own_s0       = (owner_q == OWN_S0RD);
    assign own_ar_valid = own_s0 ? s0_ar_valid : s1_ar_valid;

    // Channel routing is a pure function of registered state/owner, so every output is 0 in IDLE.
    always_comb begin
        s0_ar_ready = 1'b0;
        s0_r_valid  = 1'b0;
        s0_r_resp   = 2'b00;
        s0_r_data   = '0;
        s1_aw_ready = 1'b0;
        s1_w_ready  = 1'b0;
        s1_b_valid  = 1'b0;
        s1_b_resp   = 2'b00;
        s1_ar_ready = 1'b0;
        s1_r_valid  = 1'b0;
        s1_r_resp   = 2'b00;
        s1_r_data   = '0;
        m_aw_valid  = 1'b0;
        m_aw_addr   = '0;
        m_w_valid   = 1'b0;
        m_w_data    = '0;
        m_w_strb    = '0;
        m_b_ready   = 1'b0;
        m_ar_valid  = 1'b0;
        m_ar_addr   = '0;
        m_r_ready   = 1'b0;
        grant_o     = (state_q == IDLE) ? 2'b00 : 2'(owner_q);

        case (state_q)
            RD_ADDR: begin
                m_ar_valid = own_ar_valid;
                m_ar_addr  = own_s0 ? s0_ar_addr : s1_ar_addr;
                if (own_s0) s0_ar_ready = m_ar_ready;
                else        s1_ar_ready = m_ar_ready;
            end
            RD_DATA: begin
                m_r_ready = own_s0 ? s0_r_ready : s1_r_ready;
                if (own_s0) begin
                    s0_r_valid = m_r_valid;
                    s0_r_resp  = m_r_resp;
                    s0_r_data  = m_r_data;
                end else begin
                    s1_r_valid = m_r_valid;
                    s1_r_resp  = m_r_resp;
                    s1_r_data  = m_r_data;
                end
            end
            WR_REQ: begin
                m_aw_valid  = s1_aw_valid & ~aw_done_q;
                m_aw_addr   = s1_aw_addr;
                s1_aw_ready = m_aw_ready & ~aw_done_q;
                m_w_valid   = s1_w_valid & ~w_done_q;
                m_w_data    = s1_w_data;
                m_w_strb    = s1_w_strb;
                s1_w_ready  = m_w_ready & ~w_done_q;
            end
            WR_RESP: begin
                s1_b_valid = m_b_valid;
                s1_b_resp  = m_b_resp;
                m_b_ready  = s1_b_ready;
            end
            default: ;
        endcase
    end

    // Next-state, arbitration decision and starvation bookkeeping.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            IDLE: begin
                if (s0_ar_valid && (starve_q == CNT_W'(STARVE_LIMIT))) begin
                    owner_d = OWN_S0RD;
                    state_d = RD_ADDR;
                end else if (s1_aw_valid || s1_w_valid) begin
                    owner_d = OWN_S1WR;
                    state_d = WR_REQ;
                end else if (s1_ar_valid) begin
                    owner_d = OWN_S1RD;
                    state_d = RD_ADDR;
                end else if (s0_ar_valid) begin
                    owner_d = OWN_S0RD;
                    state_d = RD_ADDR;
                end

                if (!s0_ar_valid || (owner_d == OWN_S0RD)) starve_d = '0;
                else if (starve_q != '1)                   starve_d = starve_q + CNT_W'(1);
            end
            RD_ADDR: begin
                if (!own_ar_valid)   state_d = IDLE;
                else if (m_ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_r_valid && m_r_ready) state_d = IDLE;
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | (m_aw_valid & m_aw_ready);
                w_done_d  = w_done_q | (m_w_valid & m_w_ready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_b_valid && s1_b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) owner_d = OWN_NONE;
    end

endmodule

// File: tb/tb_ysyx_22050019_mem_rr_sched.sv
// Directed bench for the memory scheduler: reads, priority, starvation, write, error resp, reset.
module tb_ysyx_22050019_mem_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_ar_valid, s0_ar_ready, s0_r_valid, s0_r_ready;
    logic [63:0] s0_ar_addr, s0_r_data;
    logic [1:0]  s0_r_resp;
    logic        s1_aw_valid, s1_aw_ready, s1_w_valid, s1_w_ready, s1_b_valid, s1_b_ready;
    logic [63:0] s1_aw_addr, s1_w_data;
    logic [7:0]  s1_w_strb;
    logic [1:0]  s1_b_resp;
    logic        s1_ar_valid, s1_ar_ready, s1_r_valid, s1_r_ready;
    logic [63:0] s1_ar_addr, s1_r_data;
    logic [1:0]  s1_r_resp;
    logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic [63:0] m_aw_addr, m_w_data;
    logic [7:0]  m_w_strb;
    logic [1:0]  m_b_resp;
    logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [63:0] m_ar_addr, m_r_data;
    logic [1:0]  m_r_resp;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_err    = 0;
    int aw_hs    = 0;
    int w_hs     = 0;
    int lat;

    ysyx_22050019_mem_rr_sched #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_resp(s0_r_resp), .s0_r_data(s0_r_data),
        .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready), .s1_aw_addr(s1_aw_addr),
        .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready), .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb),
        .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready), .s1_b_resp(s1_b_resp),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_resp(s1_r_resp), .s1_r_data(s1_r_data),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_resp(m_r_resp), .m_r_data(m_r_data),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_aw_valid && m_aw_ready) aw_hs <= aw_hs + 1;
        if (m_w_valid && m_w_ready)   w_hs  <= w_hs + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Slave side of one read: wait for AR, hold ready low ar_delay cycles, then return data/resp.
    task automatic slave_read(input logic [63:0] exp_addr, input logic [1:0] exp_grant,
                              input int ar_delay, input logic [63:0] data,
                              input logic [1:0] resp, output int latency);
        logic is_s0;
        is_s0   = (exp_grant == 2'b01);
        latency = 0;
        while (!m_ar_valid && latency < 20) begin
            tick();
            latency++;
        end
        check("ar_valid", 64'(m_ar_valid), 64'd1);
        check("ar_addr", m_ar_addr, exp_addr);
        check("grant_rd", 64'(grant_o), 64'(exp_grant));
        for (int i = 0; i < ar_delay; i++) begin
            check("ar_ready_low", 64'({s0_ar_ready, s1_ar_ready}), 64'd0);
            tick();
        end
        m_ar_ready = 1'b1;
        #1;
        check("ar_ready_route", 64'({s0_ar_ready, s1_ar_ready}), is_s0 ? 64'd2 : 64'd1);
        tick();
        m_ar_ready = 1'b0;
        if (is_s0) s0_ar_valid = 1'b0;
        else       s1_ar_valid = 1'b0;
        m_r_valid = 1'b1;
        m_r_data  = data;
        m_r_resp  = resp;
        #1;
        check("r_valid_route", 64'({s0_r_valid, s1_r_valid}), is_s0 ? 64'd2 : 64'd1);
        check("r_data", is_s0 ? s0_r_data : s1_r_data, data);
        check("r_resp", 64'(is_s0 ? s0_r_resp : s1_r_resp), 64'(resp));
        check("r_data_other", is_s0 ? s1_r_data : s0_r_data, 64'd0);
        check("r_ready", 64'(m_r_ready), 64'd1);
        tick();
        m_r_valid = 1'b0;
        m_r_data  = '0;
        m_r_resp  = 2'b00;
        check("grant_idle", 64'(grant_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        s0_ar_valid = 0; s0_ar_addr = '0; s0_r_ready = 1;
        s1_aw_valid = 0; s1_aw_addr = '0; s1_w_valid = 0; s1_w_data = '0; s1_w_strb = '0;
        s1_b_ready = 1; s1_ar_valid = 0; s1_ar_addr = '0; s1_r_ready = 1;
        m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_resp = '0;
        m_ar_ready = 0; m_r_valid = 0; m_r_resp = '0; m_r_data = '0;
        tick();
        tick();
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_valids", 64'({m_ar_valid, m_aw_valid, m_w_valid, s0_r_valid, s1_r_valid, s1_b_valid}), 64'd0);
        check("rst_readies", 64'({s0_ar_ready, s1_ar_ready, s1_aw_ready, s1_w_ready, m_r_ready, m_b_ready}), 64'd0);
        rst = 1'b0;
        tick();

        // S0 alone
        s0_ar_valid = 1; s0_ar_addr = 64'h8000_0000;
        slave_read(64'h8000_0000, 2'b01, 2, 64'h0000_0013_0000_0297, 2'b00, lat);
        check("s0_latency", 64'(lat), 64'd1);

        // Simultaneous S0/S1 reads: S1 first
        s0_ar_valid = 1; s0_ar_addr = 64'h8000_0100;
        s1_ar_valid = 1; s1_ar_addr = 64'h8000_0200;
        slave_read(64'h8000_0200, 2'b10, 0, 64'h1111, 2'b00, lat);
        slave_read(64'h8000_0100, 2'b01, 0, 64'h2222, 2'b00, lat);

        // Starvation bound
        s0_ar_valid = 1; s0_ar_addr = 64'h8000_0500;
        for (int k = 0; k < 4; k++) begin
            s1_ar_valid = 1; s1_ar_addr = 64'h8000_0300 + 64'(k * 8);
            slave_read(64'h8000_0300 + 64'(k * 8), 2'b10, 0, 64'(k + 100), 2'b00, lat);
        end
        check("starve_at_limit", 64'(dut.starve_q), 64'd4);
        s1_ar_valid = 1; s1_ar_addr = 64'h8000_0400;
        slave_read(64'h8000_0500, 2'b01, 0, 64'h5555, 2'b00, lat);
        check("starve_cleared", 64'(dut.starve_q), 64'd0);
        slave_read(64'h8000_0400, 2'b10, 0, 64'h6666, 2'b00, lat);

        // S1 write, W accepted two cycles before AW
        s1_aw_valid = 1; s1_aw_addr = 64'h8000_1000;
        s1_w_valid = 1; s1_w_data = 64'hFF0; s1_w_strb = 8'h0F;
        tick();
        check("wr_grant", 64'(grant_o), 64'd3);
        check("wr_valids", 64'({m_aw_valid, m_w_valid, m_ar_valid}), 64'd6);
        check("wr_aw_addr", m_aw_addr, 64'h8000_1000);
        check("wr_w_data", m_w_data, 64'hFF0);
        check("wr_w_strb", 64'(m_w_strb), 64'h0F);
        m_w_ready = 1;
        #1;
        check("wr_w_first", 64'({s1_aw_ready, s1_w_ready}), 64'd1);
        tick();
        m_w_ready = 0;
        check("wr_w_done_valid", 64'({m_aw_valid, m_w_valid}), 64'd2);
        tick();
        m_aw_ready = 1;
        #1;
        check("wr_aw_ready", 64'({s1_aw_ready, s1_w_ready}), 64'd2);
        tick();
        m_aw_ready = 0; s1_aw_valid = 0; s1_w_valid = 0;
        check("wr_hs_counts", 64'({aw_hs[7:0], w_hs[7:0]}), 64'h0101);
        m_b_valid = 1; m_b_resp = 2'b00;
        #1;
        check("wr_b_route", 64'({s1_b_valid, m_b_ready, s1_b_resp}), 64'hC);
        check("wr_resp_grant", 64'(grant_o), 64'd3);
        tick();
        m_b_valid = 0;
        check("wr_idle", 64'(grant_o), 64'd0);

        // SLVERR passthrough, then a normal read
        s1_ar_valid = 1; s1_ar_addr = 64'h8000_2000;
        slave_read(64'h8000_2000, 2'b10, 1, 64'hDEAD_BEEF, 2'b10, lat);
        s1_ar_valid = 1; s1_ar_addr = 64'h8000_2008;
        slave_read(64'h8000_2008, 2'b10, 0, 64'hCAFE, 2'b00, lat);

        // Asynchronous reset during RD_DATA
        s0_ar_valid = 1; s0_ar_addr = 64'h8000_0040;
        tick();
        m_ar_ready = 1;
        tick();
        m_ar_ready = 0; s0_ar_valid = 0;
        m_r_valid = 1; m_r_data = 64'h1234;
        #1;
        check("pre_rst_r_valid", 64'(s0_r_valid), 64'd1);
        rst = 1;
        #1;
        check("async_rst_outs", 64'({s0_r_valid, m_r_ready, grant_o}), 64'd0);
        check("async_rst_data", s0_r_data, 64'd0);
        m_r_valid = 0; m_r_data = '0;
        tick();
        rst = 0;
        tick();
        check("post_rst_grant", 64'(grant_o), 64'd0);
        s0_ar_valid = 1; s0_ar_addr = 64'h8000_0080;
        slave_read(64'h8000_0080, 2'b01, 0, 64'h0BAD_F00D, 2'b00, lat);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
